// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_ctrl
// Purpose  : Sequential shift-and-add multiplier controller driving a shared
//            external 32-bit adder; yields a 64-bit {hi, lo} product.
// Revision : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_p,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_run  = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic               r_neg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_run;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_carry;
    logic [2*WIDTH-1:0] w_next;
    logic [2*WIDTH-1:0] w_result;

    // Magnitudes are formed locally so the shared adder is only used in RUN;
    // the most negative value maps onto itself and reads as an unsigned magnitude.
    assign w_mag_a = (sign && opa[WIDTH-1]) ? (~opa + WIDTH'(1)) : opa;
    assign w_mag_b = (sign && opb[WIDTH-1]) ? (~opb + WIDTH'(1)) : opb;

    assign w_run = (r_state == c_s_run);
    assign add_a = w_run ? r_acc_hi : '0;
    assign add_b = (w_run && r_acc_lo[0]) ? r_mcand : '0;

    // The adder has no carry-out; a wrapped sum is always smaller than an operand.
    assign w_carry  = (add_p < add_a);
    assign w_next   = {w_carry, add_p, r_acc_lo[WIDTH-1:1]};
    assign w_result = r_neg ? (~w_next + (2*WIDTH)'(1)) : w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_s_idle;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                c_s_idle, c_s_done: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= w_mag_a;
                        r_acc_hi <= '0;
                        r_acc_lo <= w_mag_b;
                        r_neg    <= sign & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= c_s_run;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= c_s_idle;
                    end
                end
                c_s_run: begin
                    {r_acc_hi, r_acc_lo} <= w_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last_iter) begin
                        {r_hi, r_lo} <= w_result;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_s_done;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_s_idle;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
